// File: rtl/fold_mult_sched.sv
// fold_mult_sched: round-robin request scheduler and in-order result router
// for the folded-Karatsuba constant multiplier. A credit counter bounds the
// outstanding work so the non-stallable multiplier never loses a result.
module fold_mult_sched #(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_x,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_x,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [383:0] rsp_p,
  output logic         mul_in_valid,
  output logic [127:0] mul_x,
  output logic [64:0]  mul_x1x0,
  input  logic [383:0] mul_p,
  input  logic         mul_out_valid,
  output logic         busy,
  output logic         err
);

  localparam int unsigned XW = 128;
  localparam int unsigned HW = 64;
  localparam int unsigned FW = 65;
  localparam int unsigned PW = 384;
  localparam int unsigned EW = PW + 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Credit / arbitration state
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  // Issue registers toward the multiplier
  logic          issue_v_q, issue_v_d;
  logic [XW-1:0] issue_x_q, issue_x_d;
  logic [FW-1:0] issue_f_q, issue_f_d;

  // Tag FIFO (requester ID per in-flight multiply)
  logic          tag_mem [DEPTH];
  logic [AW-1:0] tag_wr_q, tag_wr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d;
  logic [CW-1:0] tag_cnt_q, tag_cnt_d;

  // Response FIFO entries are {id, product}
  logic [EW-1:0] rsp_mem [DEPTH];
  logic [AW-1:0] rsp_wr_q, rsp_wr_d;
  logic [AW-1:0] rsp_rd_q, rsp_rd_d;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;

  logic          err_q, err_d;

  // Combinational control
  logic          can_accept;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          acc_id;
  logic [XW-1:0] acc_x;
  logic          tag_empty;
  logic          tag_push;
  logic          tag_pop;
  logic          rsp_full;
  logic          rsp_pop;
  logic          rsp_push_req;
  logic          rsp_push;
  logic [EW-1:0] rsp_head;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Round-robin grant gated by available credit; readies are low in reset
  always_comb begin
    can_accept = !reset && (cnt_q < CW'(DEPTH));
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    req0_ready = can_accept && grant0;
    req1_ready = can_accept && grant1;
    accept     = req0_ready || req1_ready;
    acc_id     = req1_ready;
    acc_x      = req1_ready ? req1_x : req0_x;
  end

  // FIFO handshakes and show-ahead response head
  always_comb begin
    tag_empty    = (tag_cnt_q == '0);
    tag_push     = accept && (tag_cnt_q != CW'(DEPTH));
    tag_pop      = mul_out_valid && !tag_empty;
    rsp_valid    = (rsp_cnt_q != '0);
    rsp_pop      = rsp_valid && rsp_ready;
    rsp_full     = (rsp_cnt_q == CW'(DEPTH));
    rsp_push_req = tag_pop;
    rsp_push     = rsp_push_req && (!rsp_full || rsp_pop);
    rsp_head     = rsp_mem[rsp_rd_q];
    rsp_id       = rsp_valid ? rsp_head[PW] : 1'b0;
    rsp_p        = rsp_valid ? rsp_head[PW-1:0] : '0;
  end

  // Next-state for credits, pointers, issue registers and sticky error
  always_comb begin
    cnt_d     = cnt_q;
    last_d    = last_q;
    issue_v_d = accept;
    issue_x_d = issue_x_q;
    issue_f_d = issue_f_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    tag_cnt_d = tag_cnt_q;
    rsp_wr_d  = rsp_wr_q;
    rsp_rd_d  = rsp_rd_q;
    rsp_cnt_d = rsp_cnt_q;
    err_d     = err_q;

    if (accept) begin
      last_d    = acc_id;
      issue_x_d = acc_x;
      issue_f_d = FW'(acc_x[XW-1:HW]) + FW'(acc_x[HW-1:0]);
    end

    case ({accept, rsp_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (tag_push) tag_wr_d = ptr_inc(tag_wr_q);
    if (tag_pop)  tag_rd_d = ptr_inc(tag_rd_q);
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase

    if (rsp_push) rsp_wr_d = ptr_inc(rsp_wr_q);
    if (rsp_pop)  rsp_rd_d = ptr_inc(rsp_rd_q);
    case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase

    // Orphan result or response overflow: the result is dropped and flagged
    if ((mul_out_valid && tag_empty) || (rsp_push_req && rsp_full && !rsp_pop)) begin
      err_d = 1'b1;
    end
  end

  // State registers; last resets to 1 so req0 wins the first contest
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      last_q    <= 1'b1;
      issue_v_q <= 1'b0;
      issue_x_q <= '0;
      issue_f_q <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      issue_v_q <= issue_v_d;
      issue_x_q <= issue_x_d;
      issue_f_q <= issue_f_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
      err_q     <= err_d;
    end
  end

  // Tag storage: written on accept, read when the matching result returns
  always_ff @(posedge clock) begin
    if (tag_push) tag_mem[tag_wr_q] <= acc_id;
  end

  // Response storage: tagged product written when the multiplier returns
  always_ff @(posedge clock) begin
    if (rsp_push) rsp_mem[rsp_wr_q] <= {tag_mem[tag_rd_q], mul_p};
  end

  assign mul_in_valid = issue_v_q;
  assign mul_x        = issue_x_q;
  assign mul_x1x0     = issue_f_q;
  assign busy         = (cnt_q != '0);
  assign err          = err_q;

endmodule

// File: tb/tb_fold_mult_sched.sv
// Bench for fold_mult_sched: 9-stage constant-multiplier model, arbitration
// and credit reference model, and an expected-response queue.
module tb_fold_mult_sched;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 9;
  localparam logic [127:0] KCONST  = 128'h1c424d77f1b750a9_9cc6df2b0ee713a2;
  localparam logic [383:0] T1_PROD = 384'h1c424d77f1b750a9_b9092ca3009e644b_9cc6df2b0ee713a2;

  typedef struct packed {
    logic         id;
    logic [383:0] p;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         req0_valid, req0_ready;
  logic [127:0] req0_x;
  logic         req1_valid, req1_ready;
  logic [127:0] req1_x;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [383:0] rsp_p;
  logic         mul_in_valid;
  logic [127:0] mul_x;
  logic [64:0]  mul_x1x0;
  logic [383:0] mul_p;
  logic         mul_out_valid;
  logic         busy, err;
  logic         inj;

  int n_checks = 0;
  int n_fail   = 0;

  fold_mult_sched #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .mul_in_valid(mul_in_valid), .mul_x(mul_x), .mul_x1x0(mul_x1x0),
    .mul_p(mul_p), .mul_out_valid(mul_out_valid),
    .busy(busy), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier: fixed latency, synchronous flush on reset
  logic [LAT-1:0] mv_q;
  logic [383:0]   mp_q [LAT];
  always @(posedge clock) begin
    if (reset) begin
      mv_q <= '0;
    end else begin
      mv_q     <= {mv_q[LAT-2:0], mul_in_valid};
      mp_q[0]  <= 384'(mul_x) * 384'(KCONST);
      for (int k = 1; k < LAT; k++) mp_q[k] <= mp_q[k-1];
    end
  end
  assign mul_out_valid = mv_q[LAT-1] | inj;
  assign mul_p         = mp_q[LAT-1];

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model state
  exp_t         sb[$];
  int           m_cnt   = 0;
  logic         m_last  = 1'b1;
  logic         prev_acc = 1'b0;
  logic [127:0] prev_x  = '0;
  logic         exp_err = 1'b0;
  logic         g0, g1, acc, hs;
  exp_t         e;

  // Per-cycle monitor: arbitration, issue, credits, responses, error flag
  always @(negedge clock) begin
    if (reset) begin
      check("rst_ready0", 384'(req0_ready), '0);
      check("rst_ready1", 384'(req1_ready), '0);
      check("rst_rsp_valid", 384'(rsp_valid), '0);
      check("rst_rsp_id", 384'(rsp_id), '0);
      check("rst_rsp_p", rsp_p, '0);
      check("rst_busy", 384'(busy), '0);
      check("rst_err", 384'(err), '0);
      check("rst_mul_in_valid", 384'(mul_in_valid), '0);
      sb.delete();
      m_cnt    = 0;
      m_last   = 1'b1;
      prev_acc = 1'b0;
      exp_err  = 1'b0;
    end else begin
      check("issue_valid", 384'(mul_in_valid), 384'(prev_acc));
      if (prev_acc) begin
        check("issue_x", 384'(mul_x), 384'(prev_x));
        check("issue_x1x0", 384'(mul_x1x0), 384'(65'(prev_x[127:64]) + 65'(prev_x[63:0])));
      end
      g0 = (m_cnt < int'(DEPTH)) && req0_valid && (!req1_valid || m_last);
      g1 = (m_cnt < int'(DEPTH)) && req1_valid && (!req0_valid || !m_last);
      check("ready0", 384'(req0_ready), 384'(g0));
      check("ready1", 384'(req1_ready), 384'(g1));
      check("busy", 384'(busy), 384'(m_cnt != 0));
      check("err", 384'(err), 384'(exp_err));
      hs = rsp_valid && rsp_ready;
      if (hs) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 384'(rsp_valid), '0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 384'(rsp_id), 384'(e.id));
          check("rsp_p", rsp_p, e.p);
        end
      end
      acc = g0 || g1;
      if (acc) begin
        e.id = g1;
        e.p  = 384'(g1 ? req1_x : req0_x) * 384'(KCONST);
        sb.push_back(e);
        m_last = g1;
      end
      prev_acc = acc;
      prev_x   = g1 ? req1_x : req0_x;
      m_cnt    = m_cnt + (acc ? 1 : 0) - (hs ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || m_cnt != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(tag, 384'(n < 300), 384'(1'b1));
    @(negedge clock);
    check({tag, "_busy"}, 384'(busy), '0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    int cnt_acc;
    logic saw;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req1_x = '0; rsp_ready = 1'b0; inj = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Single req0 with a carry-free fold; fixed 11-cycle response latency
    step();
    rsp_ready = 1'b1;
    req0_x = 128'h1_0000000000000001;
    req0_valid = 1'b1;
    @(negedge clock);
    check("t1_ready0", 384'(req0_ready), 384'(1'b1));
    step();
    req0_valid = 1'b0;
    @(negedge clock);
    check("t1_x1x0", 384'(mul_x1x0), 384'(65'h2));
    wait_rsp(lat);
    check("t1_latency", 384'(lat), 384'(11));
    check("t1_id", 384'(rsp_id), '0);
    check("t1_p", rsp_p, T1_PROD);
    drain("t1_drain");

    // Single req1 with all-ones operand; fold keeps the carry
    step();
    req1_x = '1;
    req1_valid = 1'b1;
    @(negedge clock);
    check("t2_ready1", 384'(req1_ready), 384'(1'b1));
    step();
    req1_valid = 1'b0;
    @(negedge clock);
    check("t2_x1x0", 384'(mul_x1x0), 384'(65'h1_FFFFFFFFFFFFFFFE));
    wait_rsp(lat);
    check("t2_latency", 384'(lat), 384'(11));
    check("t2_id", 384'(rsp_id), 384'(1'b1));
    check("t2_p", rsp_p, 384'({128{1'b1}}) * 384'(KCONST));
    drain("t2_drain");

    // Both requesters contend: strict alternation starting with req0
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = rand128(); req1_x = rand128();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("t3_ready0", 384'(req0_ready), 384'(i % 2 == 0));
      check("t3_ready1", 384'(req1_ready), 384'(i % 2 == 1));
      if (i > 0) check("t3_busy", 384'(busy), 384'(1'b1));
      step();
      req0_x = rand128(); req1_x = rand128();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t3_drain");

    // Backpressure: exactly DEPTH accepts, then resume as credits free up
    step();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cnt_acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cnt_acc += int'(req0_ready | req1_ready);
      step();
      req0_x = rand128(); req1_x = rand128();
    end
    check("t4_accepts", 384'(cnt_acc), 384'(DEPTH));
    @(negedge clock);
    check("t4_full_ready0", 384'(req0_ready), '0);
    check("t4_full_ready1", 384'(req1_ready), '0);
    step();
    rsp_ready = 1'b1;
    cnt_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      cnt_acc += int'(req0_ready | req1_ready);
      step();
      req0_x = rand128(); req1_x = rand128();
    end
    check("t4_resume", 384'(cnt_acc), 384'(11));
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t4_drain");

    // Reset with five multiplies in flight
    step();
    req0_valid = 1'b1;
    req0_x = rand128();
    for (int i = 0; i < 5; i++) begin
      step();
      req0_x = rand128();
    end
    req0_valid = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_ready0", 384'(req0_ready), '0);
    check("t5_ready1", 384'(req1_ready), '0);
    check("t5_rsp_valid", 384'(rsp_valid), '0);
    check("t5_rsp_id", 384'(rsp_id), '0);
    check("t5_rsp_p", rsp_p, '0);
    check("t5_busy", 384'(busy), '0);
    check("t5_err", 384'(err), '0);
    check("t5_mul_in_valid", 384'(mul_in_valid), '0);
    check("t5_mul_x", 384'(mul_x), '0);
    check("t5_mul_x1x0", 384'(mul_x1x0), '0);
    repeat (3) @(posedge clock);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 reset = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clock);
      saw |= rsp_valid;
    end
    check("t5_no_rsp", 384'(saw), '0);
    check("t5_err_after", 384'(err), '0);

    // Orphan multiplier result sets a sticky error
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    exp_err = 1'b1;
    @(negedge clock);
    check("t6_err_set", 384'(err), 384'(1'b1));
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = rand128(); req1_x = rand128();
    for (int i = 0; i < 4; i++) begin
      step();
      req0_x = rand128(); req1_x = rand128();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t6_drain");
    check("t6_err_sticky", 384'(err), 384'(1'b1));
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check("t6_err_reset", 384'(err), '0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("t6_err_cleared", 384'(err), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
